// File: rtl/contadores_lector_if.sv
// Counter-readout bus between the reader (initiator) and the counter block.
//   req        : read request from the reader
//   idx        : counter index being requested
//   counter_in : counter value returned by the counter block (combinational vs req/idx)
//   valid_in   : counter block valid, qualifies counter_in
// The master modport is the reader side; the slave modport is the counter block side.
interface contadores_lector_if #(
  parameter int CBITS = 5
);
  logic             req;
  logic [1:0]       idx;
  logic [CBITS-1:0] counter_in;
  logic             valid_in;

  modport master (output req, output idx, input counter_in, input valid_in);
  modport slave  (input req, input idx, output counter_in, output valid_in);
endinterface

// File: rtl/contadores_lector.sv
// contadores_lector: initiator side of the counter-readout interface.
// Waits for the datapath to report idle, then walks indices 0..3 issuing one
// read request per selected counter and captures the returned value into one
// of four holding registers. Losing idle during a selected read aborts the
// sweep, pulses restart and starts over from index 0 once idle returns.
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   start      : one-cycle sweep request, ignored while busy
//   rd_mask    : bit k selects counter k, sampled on accepted start
//   idle       : datapath idle indication
//   bus        : readout bus (req/idx out, counter_in/valid_in in)
//   cnt0..cnt3 : captured counter values
//   busy       : high from accepted start through the done cycle
//   done       : one-cycle pulse when the sweep completes
//   restart    : one-cycle pulse when a sweep was aborted and restarted
//   proto_err  : sticky flag, valid seen while no request outstanding
module contadores_lector #(
  parameter int CBITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           rd_mask,
  input  logic                 idle,
  contadores_lector_if.master  bus,
  output logic [CBITS-1:0]     cnt0,
  output logic [CBITS-1:0]     cnt1,
  output logic [CBITS-1:0]     cnt2,
  output logic [CBITS-1:0]     cnt3,
  output logic                 busy,
  output logic                 done,
  output logic                 restart,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [3:0]       mask_q, mask_nx;
  logic             restart_q, restart_nx;
  logic             cap_en;
  logic             req_int;
  logic [CBITS-1:0] cnt_q [4];

  // All bus/status outputs are decoded from registered state so that no
  // combinational path exists from the inputs to the outputs.
  assign req_int   = (state == S_READ) && mask_q[ptr];
  assign bus.req   = req_int;
  assign bus.idx   = (state == S_READ) ? ptr : 2'd0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign restart   = restart_q;
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];

  // Next-state logic. Each index gets exactly one READ cycle; a selected
  // index without valid means idle was lost, so the sweep goes back to WAIT
  // and starts again at index 0. Captured values are kept and overwritten on
  // the retry.
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    mask_nx    = mask_q;
    restart_nx = 1'b0;
    cap_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          mask_nx  = rd_mask;
          ptr_nx   = 2'd0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (idle) begin
          state_nx = S_READ;
        end
      end
      S_READ: begin
        if (mask_q[ptr] && !bus.valid_in) begin
          ptr_nx     = 2'd0;
          restart_nx = 1'b1;
          state_nx   = S_WAIT;
        end else begin
          cap_en = mask_q[ptr];
          if (ptr == 2'd3) begin
            state_nx = S_DONE;
          end else begin
            ptr_nx = ptr + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, pointer, mask and restart pulse registers plus the four holding
  // registers. proto_err is sticky: only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      mask_q    <= 4'd0;
      restart_q <= 1'b0;
      proto_err <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      mask_q    <= mask_nx;
      restart_q <= restart_nx;
      if (bus.valid_in && !req_int) begin
        proto_err <= 1'b1;
      end
      if (cap_en) begin
        cnt_q[ptr] <= bus.counter_in;
      end
    end
  end

endmodule

// File: tb/tb_contadores_lector.sv
// Self-checking bench for contadores_lector. A behavioural counter block
// answers requests with valid whenever idle is high. Directed scenarios are
// checked against fixed cycle patterns; random sweeps are checked against a
// sweep-level reference model that walks the selected indices per cycle.
module tb_contadores_lector;
  localparam int CBITS = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       rd_mask;
  logic             idle;
  logic             force_valid;
  logic [CBITS-1:0] cnt0, cnt1, cnt2, cnt3;
  logic             busy, done, restart, proto_err;

  logic [CBITS-1:0] ctr_vals   [4];
  logic [CBITS-1:0] retry_vals [4];

  int checks = 0;
  int errors = 0;

  // Per-cycle traces of the DUT (bit c = cycle c after the start edge).
  logic [31:0] req_tr, done_tr, busy_tr, restart_tr;
  logic [1:0]  idx_tr [32];

  // Reference model expectations.
  logic [31:0]      exp_req, exp_done, exp_busy, exp_restart, exp_read;
  logic [1:0]       exp_idx [32];
  logic [CBITS-1:0] exp_cnt [4];
  logic             idle_pat [32];

  contadores_lector_if #(.CBITS(CBITS)) bus ();

  // Counter block model: returns the addressed counter, valid while idle.
  assign bus.counter_in = ctr_vals[bus.idx];
  assign bus.valid_in   = (bus.req & idle) | force_valid;

  contadores_lector #(.CBITS(CBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_mask   (rd_mask),
    .idle      (idle),
    .bus       (bus),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .busy      (busy),
    .done      (done),
    .restart   (restart),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_pattern(input int rise, input int drop_lo, input int drop_hi);
    for (int c = 0; c < 32; c++) begin
      idle_pat[c] = (c >= rise) && !(c >= drop_lo && c < drop_hi);
    end
  endtask

  task automatic randomize_vals();
    for (int k = 0; k < 4; k++) begin
      ctr_vals[k]   = CBITS'($urandom);
      retry_vals[k] = CBITS'($urandom);
    end
  endtask

  // Drives one sweep: start in cycle 0, idle from idle_pat, counter values
  // swapped to retry_vals at swap_cyc, optional extra start at extra_start.
  task automatic do_sweep(input logic [3:0] mask, input int swap_cyc, input int extra_start);
    req_tr = '0; done_tr = '0; busy_tr = '0; restart_tr = '0;
    for (int c = 0; c < 32; c++) idx_tr[c] = 2'd0;
    rd_mask = mask;
    idle    = idle_pat[0];
    start   = 1'b1;
    tick();
    for (int c = 1; c < 32; c++) begin
      if (swap_cyc > 0 && c == swap_cyc) ctr_vals = retry_vals;
      idle    = idle_pat[c];
      start   = (c == extra_start);
      rd_mask = (c == extra_start) ? mask : ~mask;
      #1;
      req_tr[c]     = bus.req;
      idx_tr[c]     = bus.idx;
      done_tr[c]    = done;
      busy_tr[c]    = busy;
      restart_tr[c] = restart;
      tick();
    end
    start = 1'b0;
  endtask

  // Sweep-level reference: waits for idle, then visits indices 0..3 one
  // cycle each; a selected index read while idle is low aborts back to
  // waiting with a restart flag on the following cycle.
  task automatic model_sweep(input logic [3:0] mask, input int swap_cyc, input int extra_start);
    logic [CBITS-1:0] bv [4];
    int c, k, s, d;
    bv = ctr_vals;
    exp_req = '0; exp_done = '0; exp_busy = '0; exp_restart = '0; exp_read = '0;
    for (int i = 0; i < 32; i++) exp_idx[i] = 2'd0;
    s = 1;
    for (int n = 0; n < 2; n++) begin
      if (s > 0) begin
        c = s; k = -1; d = 0;
        while (c < 31 && d == 0) begin
          exp_busy[c] = 1'b1;
          if (k < 0) begin
            if (idle_pat[c]) k = 0;
            c++;
          end else if (k == 4) begin
            exp_done[c] = 1'b1;
            d = c;
          end else begin
            exp_read[c] = 1'b1;
            exp_idx[c]  = 2'(k);
            if (mask[k]) begin
              exp_req[c] = 1'b1;
              if (idle_pat[c]) begin
                exp_cnt[k] = (swap_cyc > 0 && c >= swap_cyc) ? retry_vals[k] : bv[k];
              end else begin
                exp_restart[c+1] = 1'b1;
                k = -2;
              end
            end
            k++;
            c++;
          end
        end
        s = (d > 0 && extra_start > d) ? extra_start + 1 : 0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; idle = 1'b0; force_valid = 1'b0; rd_mask = 4'd0;
    for (int k = 0; k < 4; k++) begin
      ctr_vals[k] = '0; retry_vals[k] = '0; exp_cnt[k] = '0;
    end
    tick(); tick();
    checks++;
    if ({bus.req, bus.idx, busy, done, restart, proto_err} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 0000000", {bus.req, bus.idx, busy, done, restart, proto_err});
    end
    checks++;
    if ({cnt3, cnt2, cnt1, cnt0} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_cnt got %h want 0", {cnt3, cnt2, cnt1, cnt0});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_sweep();
    ctr_vals[0] = 5'd3; ctr_vals[1] = 5'd7; ctr_vals[2] = 5'd0; ctr_vals[3] = 5'd31;
    set_idle_pattern(0, 0, 0);
    do_sweep(4'hF, 0, 0);
    checks++;
    if (req_tr[8:1] !== 8'b0001_1110) begin
      errors++; $display("[TB] FAIL full_req got %b want 00011110", req_tr[8:1]);
    end
    checks++;
    if ({idx_tr[5], idx_tr[4], idx_tr[3], idx_tr[2]} !== 8'b11_10_01_00) begin
      errors++; $display("[TB] FAIL full_idx got %b want 11100100", {idx_tr[5], idx_tr[4], idx_tr[3], idx_tr[2]});
    end
    checks++;
    if (done_tr[8:1] !== 8'b0010_0000 || busy_tr[8:1] !== 8'b0011_1111) begin
      errors++; $display("[TB] FAIL full_done_busy got %b/%b want 00100000/00111111", done_tr[8:1], busy_tr[8:1]);
    end
    checks++;
    if ({cnt3, cnt2, cnt1, cnt0} !== {5'd31, 5'd0, 5'd7, 5'd3}) begin
      errors++; $display("[TB] FAIL full_cnt got %0d %0d %0d %0d want 31 0 7 3", cnt3, cnt2, cnt1, cnt0);
    end
  endtask

  task automatic test_wait_idle();
    randomize_vals();
    set_idle_pattern(10, 0, 0);
    do_sweep(4'hF, 0, 0);
    checks++;
    if (req_tr[16:1] !== 16'b0011_1100_0000_0000) begin
      errors++; $display("[TB] FAIL wait_req got %b want 0011110000000000", req_tr[16:1]);
    end
    checks++;
    if (done_tr[16:1] !== 16'h4000 || busy_tr[16:1] !== 16'h7FFF) begin
      errors++; $display("[TB] FAIL wait_done_busy got %h/%h want 4000/7fff", done_tr[16:1], busy_tr[16:1]);
    end
  endtask

  task automatic test_mask();
    logic [CBITS-1:0] n1, n3;
    randomize_vals();
    ctr_vals[0] = 5'd5; ctr_vals[2] = 5'd9;
    set_idle_pattern(0, 0, 0);
    do_sweep(4'hF, 0, 0);
    randomize_vals();
    n1 = ctr_vals[1]; n3 = ctr_vals[3];
    do_sweep(4'b1010, 0, 0);
    checks++;
    if (req_tr[8:1] !== 8'b0001_0100) begin
      errors++; $display("[TB] FAIL mask_req got %b want 00010100", req_tr[8:1]);
    end
    checks++;
    if (done_tr[8:1] !== 8'b0010_0000) begin
      errors++; $display("[TB] FAIL mask_done got %b want 00100000", done_tr[8:1]);
    end
    checks++;
    if ({cnt3, cnt2, cnt1, cnt0} !== {n3, 5'd9, n1, 5'd5}) begin
      errors++; $display("[TB] FAIL mask_cnt got %0d %0d %0d %0d want %0d 9 %0d 5", cnt3, cnt2, cnt1, cnt0, n3, n1);
    end
    do_sweep(4'b0000, 0, 0);
    checks++;
    if (req_tr !== 32'd0 || done_tr[8:1] !== 8'b0010_0000 || {cnt3, cnt2, cnt1, cnt0} !== {n3, 5'd9, n1, 5'd5}) begin
      errors++; $display("[TB] FAIL mask_zero req %h done %b cnt %0d %0d %0d %0d", req_tr, done_tr[8:1], cnt3, cnt2, cnt1, cnt0);
    end
  endtask

  task automatic test_abort();
    randomize_vals();
    set_idle_pattern(0, 4, 8);
    do_sweep(4'hF, 5, 0);
    checks++;
    if (req_tr[16:1] !== 16'b0000_1111_0000_1110) begin
      errors++; $display("[TB] FAIL abort_req got %b want 0000111100001110", req_tr[16:1]);
    end
    checks++;
    if (restart_tr[16:1] !== 16'h0010 || done_tr[16:1] !== 16'h1000) begin
      errors++; $display("[TB] FAIL abort_pulses got %h/%h want 0010/1000", restart_tr[16:1], done_tr[16:1]);
    end
    checks++;
    if ({cnt3, cnt2, cnt1, cnt0} !== {retry_vals[3], retry_vals[2], retry_vals[1], retry_vals[0]} || proto_err !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_cnt got %0d %0d %0d %0d perr %b want %0d %0d %0d %0d 0",
        cnt3, cnt2, cnt1, cnt0, proto_err, retry_vals[3], retry_vals[2], retry_vals[1], retry_vals[0]);
    end
  endtask

  task automatic test_back_to_back();
    int starts [3] = '{3, 6, 7};
    logic [15:0] want_done [3] = '{16'h0020, 16'h0020, 16'h1020};
    logic [15:0] want_busy [3] = '{16'h003F, 16'h003F, 16'h1FBF};
    set_idle_pattern(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      randomize_vals();
      do_sweep(4'hF, 0, starts[i]);
      checks++;
      if (done_tr[16:1] !== want_done[i] || busy_tr[16:1] !== want_busy[i]) begin
        errors++; $display("[TB] FAIL b2b_start%0d got %h/%h want %h/%h", starts[i], done_tr[16:1], busy_tr[16:1], want_done[i], want_busy[i]);
      end
    end
  endtask

  task automatic test_random();
    int rise, dlo, dhi, swap;
    logic [3:0] mask;
    logic idx_bad;
    reset = 1'b1; #1;
    for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
    tick(); reset = 1'b0; tick();
    for (int it = 0; it < 10; it++) begin
      randomize_vals();
      mask = 4'($urandom);
      rise = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) begin
        dlo  = ((rise == 0) ? 2 : rise + 1) + $urandom_range(0, 3);
        dhi  = dlo + $urandom_range(1, 4);
        swap = dlo + 1;
      end else begin
        dlo = 0; dhi = 0; swap = 0;
      end
      set_idle_pattern(rise, dlo, dhi);
      model_sweep(mask, swap, 0);
      do_sweep(mask, swap, 0);
      idx_bad = 1'b0;
      for (int c = 0; c < 32; c++) if (exp_read[c] && idx_tr[c] !== exp_idx[c]) idx_bad = 1'b1;
      checks++;
      if (req_tr !== exp_req || idx_bad) begin
        errors++; $display("[TB] FAIL rand%0d_req got %h want %h idx_bad %b", it, req_tr, exp_req, idx_bad);
      end
      checks++;
      if (done_tr !== exp_done || busy_tr !== exp_busy || restart_tr !== exp_restart) begin
        errors++; $display("[TB] FAIL rand%0d_ctrl got %h/%h/%h want %h/%h/%h", it, done_tr, busy_tr, restart_tr, exp_done, exp_busy, exp_restart);
      end
      checks++;
      if ({cnt3, cnt2, cnt1, cnt0} !== {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]}) begin
        errors++; $display("[TB] FAIL rand%0d_cnt got %0d %0d %0d %0d want %0d %0d %0d %0d", it,
          cnt3, cnt2, cnt1, cnt0, exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]);
      end
    end
  endtask

  task automatic test_proto_err();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("[TB] FAIL perr_clear got %b want 0", proto_err);
    end
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("[TB] FAIL perr_set got %b want 1", proto_err);
    end
    randomize_vals();
    set_idle_pattern(0, 0, 0);
    do_sweep(4'hF, 0, 0);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("[TB] FAIL perr_sticky got %b want 1", proto_err);
    end
    reset = 1'b1; #1;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("[TB] FAIL perr_reset got %b want 0", proto_err);
    end
    tick(); reset = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    randomize_vals();
    ctr_vals[0] = ctr_vals[0] | 5'd1;
    idle = 1'b1; rd_mask = 4'hF; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    checks++;
    if (bus.req !== 1'b1 || bus.idx !== 2'd1 || cnt0 !== ctr_vals[0]) begin
      errors++; $display("[TB] FAIL mid_pre req %b idx %0d cnt0 %0d want 1 1 %0d", bus.req, bus.idx, cnt0, ctr_vals[0]);
    end
    #2; reset = 1'b1; #1;
    checks++;
    if ({bus.req, busy, done, restart} !== 4'd0 || {cnt3, cnt2, cnt1, cnt0} !== '0) begin
      errors++; $display("[TB] FAIL mid_reset ctrl %b cnt %h want 0000 0", {bus.req, busy, done, restart}, {cnt3, cnt2, cnt1, cnt0});
    end
    tick(); reset = 1'b0; tick();
    randomize_vals();
    set_idle_pattern(0, 0, 0);
    do_sweep(4'hF, 0, 0);
    checks++;
    if (done_tr[8:1] !== 8'b0010_0000 || {cnt3, cnt2, cnt1, cnt0} !== {ctr_vals[3], ctr_vals[2], ctr_vals[1], ctr_vals[0]}) begin
      errors++; $display("[TB] FAIL mid_resweep done %b cnt %0d %0d %0d %0d", done_tr[8:1], cnt3, cnt2, cnt1, cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_wait_idle();
    test_mask();
    test_abort();
    test_back_to_back();
    test_random();
    test_proto_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
